ct_merge_wrr: RTL and testbench

- Packet-aware N:1 merge for the ct_ streaming interconnect; next generation of the basic round-robin merge.
- Adds a selectable arbitration mode (round-robin or fixed priority) and a per-grant packet quantum, so one input can send several back-to-back packets without re-arbitrating.
- Adds an optional registered output (skid buffer) to break the i_ready timing path.
- Sits in front of shared links, e.g. the NoC ingress or a DMA write port.

---
 rtl/ct_pkg.sv | 12 +
 rtl/ct_skid_buf.sv | 32 +++
 rtl/ct_merge_wrr.sv | 100 ++++++++++
 tb/tb_ct_merge_wrr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_pkg.sv
// ct_pkg: shared constants, state encoding and helpers for the ct_ streaming interconnect.
package ct_pkg;
  localparam int MODE_RR = 0;
  localparam int MODE_PRIO = 1;
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ct_skid_buf.sv
// ct_skid_buf: 2-entry registered skid buffer; upstream ready depends only on occupancy.
module ct_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);
  logic [1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic push, pop;
  assign s_ready_o = cnt_q != 2'd2;
  assign m_valid_o = cnt_q != 2'd0;
  assign m_data_o = d0_q;
  always_comb begin
    push = s_valid_i && s_ready_o;
    pop = m_valid_o && m_ready_i;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    d0_d = (pop && cnt_q == 2'd2) ? d1_q : ((push && (cnt_q == 2'd0 || pop)) ? s_data_i : d0_q);
    d1_d = (push && !pop && cnt_q == 2'd1) ? s_data_i : d1_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= reset ? 2'd0 : cnt_d;
    d0_q <= d0_d;
    d1_q <= d1_d;
  end
endmodule

// File: rtl/ct_merge_wrr.sv
// ct_merge_wrr: packet-aware N:1 merge with RR/priority arbitration and a per-grant packet quantum.
module ct_merge_wrr import ct_pkg::*; #(
  parameter int RADIX = 2,
  parameter int WIDTH = 32,
  parameter int EOP_LOC = 0,
  parameter int MODE = 0,
  parameter int QUANTUM = 1,
  parameter int OUT_REG = 1,
  localparam int GW = clog2(RADIX) > 1 ? clog2(RADIX) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RADIX*WIDTH-1:0] i_data,
  input  logic [RADIX-1:0]       i_valid,
  output logic [RADIX-1:0]       o_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [GW-1:0]          o_grant,
  output logic                   o_busy
);
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic [7:0] pkt_cnt_q, pkt_cnt_d;
  logic bound_q, bound_d;
  logic accept, g_valid, g_eop, beat;
  logic [WIDTH-1:0] g_data;
  function automatic int scan(input int i, input int last);
    return MODE == MODE_PRIO ? i - 1 : (last + i) % RADIX;
  endfunction
  assign g_data = i_data[WIDTH*int'(grant_q) +: WIDTH];
  assign g_valid = i_valid[grant_q];
  assign g_eop = g_data[EOP_LOC];
  assign o_busy = state_q == S_BUSY;
  assign o_grant = grant_q;
  assign beat = o_busy && g_valid && accept;
  always_comb begin
    o_ready = '0;
    o_ready[grant_q] = o_busy && accept;
  end
  // Scan from farthest to nearest so the last hit is the first index in scan order.
  always_comb begin
    win = '0;
    for (int i = RADIX; i >= 1; i--)
      if (i_valid[scan(i, int'(last_q))]) win = GW'(scan(i, int'(last_q)));
  end
  // bound_q marks a packet boundary inside a multi-packet grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    pkt_cnt_d = pkt_cnt_q;
    bound_d = bound_q;
    if (state_q == S_IDLE) begin
      if (|i_valid) begin
        state_d = S_BUSY;
        grant_d = win;
        last_d = win;
        pkt_cnt_d = '0;
        bound_d = 1'b0;
      end
    end else if (bound_q && !g_valid) begin
      state_d = S_IDLE;
    end else if (beat) begin
      bound_d = g_eop;
      if (g_eop) begin
        pkt_cnt_d = pkt_cnt_q + 8'd1;
        state_d = ({1'b0, pkt_cnt_q} + 9'd1 == 9'(QUANTUM)) ? S_IDLE : S_BUSY;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q <= GW'(RADIX - 1);
      pkt_cnt_q <= '0;
      bound_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
      bound_q <= bound_d;
    end
  end
  generate
    if (OUT_REG != 0) begin : g_reg
      ct_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk(clk), .reset(reset),
        .s_data_i(g_data), .s_valid_i(o_busy && g_valid), .s_ready_o(accept),
        .m_data_o(o_data), .m_valid_o(o_valid), .m_ready_i(i_ready)
      );
    end else begin : g_comb
      assign accept = i_ready;
      assign o_valid = o_busy && g_valid;
      assign o_data = g_data;
    end
  endgenerate
endmodule

// File: tb/tb_ct_merge_wrr.sv
// tb_ct_merge_wrr: three merge configurations driven by per-input packet sources and checked by output scoreboards.
module tb_ct_merge_wrr;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] id [3];
  logic [3:0] iv [3];
  logic [3:0] ordy [3];
  logic [15:0] od [3];
  logic ov [3];
  logic ir [3];
  logic [1:0] og [3];
  logic ob [3];
  logic [15:0] sq [12][$];
  logic [15:0] exq [3][$];
  int fcnt [12];
  int fcq [$];
  int cyc;
  bit fire [12];
  int tot = 0;
  int bad = 0;
  typedef struct { logic [3:0] mask; logic [1:0] g; } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  ct_merge_wrr #(.RADIX(4), .WIDTH(16), .EOP_LOC(0), .MODE(0), .QUANTUM(1), .OUT_REG(1)) u_a (
    .clk(clk), .reset(reset), .i_data(id[0]), .i_valid(iv[0]), .o_ready(ordy[0]), .o_data(od[0]),
    .o_valid(ov[0]), .i_ready(ir[0]), .o_grant(og[0]), .o_busy(ob[0]));
  ct_merge_wrr #(.RADIX(4), .WIDTH(16), .EOP_LOC(0), .MODE(0), .QUANTUM(3), .OUT_REG(0)) u_b (
    .clk(clk), .reset(reset), .i_data(id[1]), .i_valid(iv[1]), .o_ready(ordy[1]), .o_data(od[1]),
    .o_valid(ov[1]), .i_ready(ir[1]), .o_grant(og[1]), .o_busy(ob[1]));
  ct_merge_wrr #(.RADIX(4), .WIDTH(16), .EOP_LOC(0), .MODE(1), .QUANTUM(1), .OUT_REG(0)) u_c (
    .clk(clk), .reset(reset), .i_data(id[2]), .i_valid(iv[2]), .o_ready(ordy[2]), .o_data(od[2]),
    .o_valid(ov[2]), .i_ready(ir[2]), .o_grant(og[2]), .o_busy(ob[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int k, input int tag, input int b, input int beats);
    return {4'(k), 7'(tag), 4'(b), 1'(b == beats - 1)};
  endfunction

  task automatic send(input int n, input int k, input int beats, input int tag);
    for (int b = 0; b < beats; b++) sq[n*4+k].push_back(mk(k, tag, b, beats));
  endtask

  task automatic expect_pkt(input int n, input int k, input int tag, input int beats);
    for (int b = 0; b < beats; b++) exq[n].push_back(mk(k, tag, b, beats));
  endtask

  function automatic int pending(input int n);
    int s;
    s = exq[n].size();
    for (int k = 0; k < 4; k++) s += sq[n*4+k].size();
    return s;
  endfunction

  task automatic wait_drain(input int n);
    int t;
    t = 0;
    while (pending(n) != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("drain%0d", n), pending(n), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Sources: sample handshakes mid-cycle, advance queues just after the edge; outputs go to the scoreboards.
  initial begin
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      fire[i] = 1'b0;
      fcnt[i] = 0;
    end
    for (int n = 0; n < 3; n++) begin
      iv[n] = '0;
      id[n] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 12; i++) fire[i] = !reset && iv[i/4][i%4] && ordy[i/4][i%4];
      for (int n = 0; n < 3; n++)
        if (!reset && ov[n] && ir[n]) begin
          if (exq[n].size() == 0) begin
            tot++;
            bad++;
            $display("FAIL out%0d: unexpected beat %0h", n, od[n]);
          end else chk($sformatf("out%0d", n), od[n], exq[n].pop_front());
        end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 12; i++)
        if (fire[i]) begin
          void'(sq[i].pop_front());
          fcnt[i]++;
          if (i < 4) fcq.push_back(cyc);
        end
      for (int i = 0; i < 12; i++) begin
        iv[i/4][i%4] = sq[i].size() > 0;
        id[i/4][(i%4)*16 +: 16] = sq[i].size() > 0 ? sq[i][0] : 16'h0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, f0;
    tbl[0] = '{4'b0110, 2'd1};
    tbl[1] = '{4'b0101, 2'd0};
    tbl[2] = '{4'b1100, 2'd2};
    tbl[3] = '{4'b1111, 2'd0};
    tbl[4] = '{4'b1010, 2'd1};
    tbl[5] = '{4'b1000, 2'd3};
    reset = 1'b1;
    for (int n = 0; n < 3; n++) ir[n] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk("rst_valid", ov[n], 0);
      chk("rst_busy", ob[n], 0);
      chk("rst_ready", ordy[n], 0);
      chk("rst_grant", og[n], 0);
    end
    @(posedge clk);
    #2 reset = 1'b0;

    // RR fairness, quantum 1: one bubble between consecutive packets
    fcq.delete();
    for (int k = 0; k < 4; k++) for (int p = 0; p < 2; p++) send(0, k, 2, p);
    for (int p = 0; p < 2; p++) for (int k = 0; k < 4; k++) expect_pkt(0, k, p, 2);
    wait_drain(0);
    chk("rr_fires", fcq.size(), 16);
    if (fcq.size() == 16)
      for (int p = 0; p < 7; p++) begin
        chk("rr_b2b", fcq[2*p+1] - fcq[2*p], 1);
        chk("rr_bubble", fcq[2*p+2] - fcq[2*p+1], 2);
      end

    // Quantum 3: 1,1,1,2,1,1
    for (int i = 0; i < 5; i++) send(1, 1, 1, i);
    send(1, 2, 1, 0);
    for (int i = 0; i < 3; i++) expect_pkt(1, 1, i, 1);
    expect_pkt(1, 2, 0, 1);
    expect_pkt(1, 1, 3, 1);
    expect_pkt(1, 1, 4, 1);
    wait_drain(1);

    // Packet hold: input 3 arrives mid-packet and must wait for input 0's EOP
    f0 = fcnt[0];
    send(0, 0, 6, 5);
    expect_pkt(0, 0, 5, 6);
    t = 0;
    while (fcnt[0] < f0 + 2 && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    send(0, 3, 2, 6);
    expect_pkt(0, 3, 6, 2);
    t = 0;
    while (sq[0].size() > 0 && t < 50) begin
      @(negedge clk);
      chk("hold_ready3", ordy[0][3], 0);
      t++;
    end
    wait_drain(0);

    // Priority mode, table-driven: first grant is the lowest valid index
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        if (tbl[r].mask[k]) begin
          send(2, k, 1, r);
          expect_pkt(2, k, r, 1);
        end
      t = 0;
      while (!ob[2] && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("prio_grant%0d", r), og[2], tbl[r].g);
      wait_drain(2);
    end
    for (int i = 0; i < 3; i++) send(2, 1, 1, 10 + i);
    for (int i = 0; i < 2; i++) send(2, 2, 1, 20 + i);
    for (int i = 0; i < 3; i++) expect_pkt(2, 1, 10 + i, 1);
    for (int i = 0; i < 2; i++) expect_pkt(2, 2, 20 + i, 1);
    wait_drain(2);

    // Backpressure through the skid buffer: i_ready 1,0,0,1
    send(0, 1, 4, 7);
    expect_pkt(0, 1, 7, 4);
    t = 0;
    while (!(iv[0][1] && ordy[0][1]) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("lat_pre", ov[0], 0);
    @(posedge clk);
    #2 ir[0] = 1'b1;
    @(negedge clk);
    chk("lat_valid", ov[0], 1);
    chk("lat_data", od[0], mk(1, 7, 0, 4));
    @(posedge clk);
    #2 ir[0] = 1'b0;
    @(negedge clk);
    chk("skid_one", ordy[0][1], 1);
    @(posedge clk);
    #2 ir[0] = 1'b0;
    @(negedge clk);
    chk("accept_drop", ordy[0][1], 0);
    @(posedge clk);
    #2 ir[0] = 1'b1;
    wait_drain(0);

    // Reset during beat 2 of a packet: nothing partial survives, input 0 wins first
    f0 = fcnt[2];
    send(0, 2, 4, 9);
    exq[0].push_back(mk(2, 9, 0, 4));
    t = 0;
    while (fcnt[2] < f0 + 2 && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) sq[k].delete();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ov[0], 0);
    chk("mid_rst_busy", ob[0], 0);
    chk("mid_rst_ready", ordy[0], 0);
    chk("mid_rst_grant", og[0], 0);
    @(posedge clk);
    #2;
    send(0, 0, 1, 11);
    send(0, 2, 1, 11);
    send(0, 3, 1, 11);
    expect_pkt(0, 0, 11, 1);
    expect_pkt(0, 2, 11, 1);
    expect_pkt(0, 3, 11, 1);
    t = 0;
    while (!ob[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("post_rst_grant", og[0], 0);
    wait_drain(0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
